generator: RTL and testbench
============================

Name: generator

Overview:
- Free-running address generator for a waveform/lookup ROM, built as a phase accumulator advanced by a modulo prescaler.
- Produces a 12-bit read address that sweeps the ROM cyclically; the sweep rate is set by the parameters.
- Sits between the system clock/reset and a 4096-entry sample ROM.
- Has no runtime controls; it is configured only through parameters.

Parameters:
- ACC_W, 24, phase accumulator width; must be at least 12.
- STEP, 4096, phase increment added on each tick; 4096 with ACC_W=24 gives +1 address per tick.
- DIV, 1, prescaler modulus; one tick every DIV clock cycles; must be at least 1.
- ADDR_W, 12, output address width; fixed at 12.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- address  output  12  ROM read address, equal to acc[ACC_W-1 -: 12].

Behaviour:
- Registers:
  - prescaler counter pcnt, width clog2(DIV) with a minimum of 1 bit.
  - phase accumulator acc, ACC_W bits.
- Reset:
  - rst=1 immediately forces pcnt=0 and acc=0, independent of clk; therefore address=0.
  - Held while rst=1.
- Prescaler:
  - Counts 0..DIV-1 on each rising clk edge.
  - tick = (pcnt==DIV-1). When tick is high, pcnt wraps to 0 on the next edge.
  - For DIV=1, tick is constantly 1.
- Accumulator:
  - On a rising edge with tick=1: acc <= acc + STEP, modulo 2^ACC_W (natural overflow, carry discarded).
  - With tick=0, acc holds.
- Output:
  - address is a direct slice of the acc register: no extra pipeline stage and no combinational path from rst other than via the async clear.
- Latency:
  - Only edges with rst=0 count; these are edges after rst deasserts.
  - The first such edge, n=1, sets address to the upper 12 bits of STEP.
  - With the defaults, address = n after edge n.
  - With general DIV, the first increment occurs on edge DIV.
- Wrap-around:
  - With the defaults, address goes 4094, 4095, 0, 1 … with no stall or glitch cycle.
  - For a general STEP, the fractional bits below the address slice carry into it exactly as unsigned addition dictates.
- Reset mid-operation:
  - Asserting rst at any time clears pcnt, acc and address asynchronously.
  - After release, counting restarts from 0 exactly as after power-up.
  - No state survives reset.
- Reset release:
  - Deassertion is treated as synchronous-safe. The edge coincident with or after the falling edge of rst performs the first count.
  - The bench releases rst away from rising edges.
- STEP=0: address stays 0 forever; this is legal.
- STEP ≥ 2^ACC_W: only the lower ACC_W bits are used.
- Output drives continuously, with no X after reset.

Test Plan:
- Power-up reset:
  - Stimulus: rst=1 from t=1ns to t=6ns, clk period 2ns.
  - Required: address=0 throughout reset; address=1 after the first edge at 7ns, 2 at 9ns, 3 at 11ns; address=47 at t≈99ns.
- Wrap:
  - Stimulus: defaults, run 4100 cycles after reset.
  - Required: the sequence 4094, 4095, 0, 1 on consecutive edges.
- Mid-run reset:
  - Stimulus: at address=20, pulse rst for 3ns between edges.
  - Required: address drops to 0 immediately without waiting for clk, then counts 1, 2, 3 after release.
- Prescaler:
  - Stimulus: DIV=3, STEP=4096.
  - Required: address holds for 2 edges and increments on every 3rd edge (0, 0, 1, 1, 1, 2 …); first increment on the 3rd edge after release.
- Fractional step:
  - Stimulus: STEP=2048.
  - Required: address advances every second edge (0, 1, 1, 2, 2 …, sampled after edges 1 to 5 as 0, 1, 1, 2, 2).
- Large step:
  - Stimulus: STEP=0x100000.
  - Required: address advances by 256 per edge (256, 512, …, 3840, 0).

Source files
------------

// File: rtl/generator.sv
`timescale 1ns/1ps
// Phase-accumulator ROM address generator advanced by a modulo-DIV prescaler.
// Latency: the address is a direct register slice; the first step lands on the DIV-th edge after reset.
// Backpressure: none; free-running. Ports: clk, rst (async active-high), address (ROM read address).
module generator #(
    parameter int              ACC_W  = 24,
    parameter longint unsigned STEP   = 4096,
    parameter int              DIV    = 1,
    parameter int              ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] address
);

    // A one-bit counter is kept even for DIV=1 so the compare below stays well formed.
    localparam int              PW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   P_LAST = PW'(DIV - 1);
    // Only the low ACC_W bits of the increment matter; the accumulator wraps naturally.
    localparam logic [ACC_W-1:0] STEP_W = ACC_W'(STEP);

    logic [PW-1:0]    pcnt;
    logic [ACC_W-1:0] acc;
    logic             tick;

    // For DIV=1 both pcnt and P_LAST are stuck at zero, so tick is constantly high.
    assign tick = (pcnt == P_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            acc  <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
            if (tick) begin
                acc <= acc + STEP_W;
            end
        end
    end

    // Upper bits of the phase form the address; fractional bits below carry in.
    assign address = acc[ACC_W-1 -: ADDR_W];

endmodule

// File: tb/tb_generator.sv
`timescale 1ns/1ps
// Bench for generator: six instances with different STEP/DIV share clk and rst.
// A closed-form model pushes expected addresses at each rising edge; they are popped
// and compared half a nanosecond later, with extra constant checks at key points.
module tb_generator;

    localparam int NI = 6;

    logic        clk;
    logic        rst;
    logic [11:0] a_def, a_div3, a_frac, a_big, a_zero, a_ovr;

    generator u_def  (.clk(clk), .rst(rst), .address(a_def));
    generator #(.DIV(3))                 u_div3 (.clk(clk), .rst(rst), .address(a_div3));
    generator #(.STEP(2048))             u_frac (.clk(clk), .rst(rst), .address(a_frac));
    generator #(.STEP(64'h0010_0000))    u_big  (.clk(clk), .rst(rst), .address(a_big));
    generator #(.STEP(0))                u_zero (.clk(clk), .rst(rst), .address(a_zero));
    generator #(.STEP(64'h0100_1000))    u_ovr  (.clk(clk), .rst(rst), .address(a_ovr));

    initial clk = 1'b0;
    always #1 clk = ~clk;

    typedef struct {
        int unsigned e [NI];
    } exp_t;

    exp_t q[$];

    int vectors    = 0;
    int miscompares = 0;
    int n          = 0;  // rising edges since the last reset release

    longint unsigned steps [NI] = '{64'd4096, 64'd4096, 64'd2048, 64'h0010_0000, 64'd0, 64'h0100_1000};
    int              divs  [NI] = '{1, 3, 1, 1, 1, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s n=%0d got %0d expected %0d", tag, n, obs, exp);
        end
    endtask

    // Independent closed form: number of ticks times STEP, truncated to 24 bits, top 12 bits.
    function automatic int unsigned model(input int edges, input int div, input longint unsigned step);
        longint unsigned ticks;
        longint unsigned ph;
        ticks = longint'(edges / div);
        ph    = (ticks * step) & 64'hFF_FFFF;
        return int'(ph >> 12);
    endfunction

    function automatic logic [11:0] dut_out(input int i);
        case (i)
            0: return a_def;
            1: return a_div3;
            2: return a_frac;
            3: return a_big;
            4: return a_zero;
            default: return a_ovr;
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < NI; i++) chk($sformatf("%s[%0d]", tag, i), {20'd0, dut_out(i)}, 32'd0);
    endtask

    // One rising edge: push the model's prediction, then sample away from the edge.
    task automatic step_edge();
        exp_t x;
        exp_t y;
        @(posedge clk);
        n++;
        for (int i = 0; i < NI; i++) x.e[i] = model(n, divs[i], steps[i]);
        q.push_back(x);
        #0.5;
        if (q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            y = q.pop_front();
            for (int i = 0; i < NI; i++) chk($sformatf("sb[%0d]", i), {20'd0, dut_out(i)}, y.e[i]);
        end
    endtask

    int div3_tab [6] = '{0, 0, 1, 1, 1, 2};
    int frac_tab [5] = '{0, 1, 1, 2, 2};

    initial begin
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 check_all_zero("rst_t2");
        #2 check_all_zero("rst_t4");
        #2 rst = 1'b0;              // t=6, between edges
        n = 0;

        // Power-up run: first edge at 7ns, n=47 at 99ns.
        for (int k = 0; k < 47; k++) begin
            step_edge();
            if (n <= 3) chk("pwr_def", {20'd0, a_def}, n);
            if (n <= 6) chk("div3_seq", {20'd0, a_div3}, div3_tab[n-1]);
            if (n <= 5) chk("frac_seq", {20'd0, a_frac}, frac_tab[n-1]);
            if (n <= 16) chk("big_seq", {20'd0, a_big}, (n * 256) % 4096);
        end
        chk("t99_def", {20'd0, a_def}, 32'd47);

        // Run across the default wrap point.
        while (n < 4100) begin
            step_edge();
            if (n == 4094) chk("wrap_4094", {20'd0, a_def}, 32'd4094);
            if (n == 4095) chk("wrap_4095", {20'd0, a_def}, 32'd4095);
            if (n == 4096) chk("wrap_0",    {20'd0, a_def}, 32'd0);
            if (n == 4097) chk("wrap_1",    {20'd0, a_def}, 32'd1);
        end

        // Mid-run reset: restart, count to 20, then pulse rst between edges.
        rst = 1'b1;
        #0.3 check_all_zero("rst_a");
        #0.7 rst = 1'b0;            // edge+1.5 relative to the last sampled edge
        n = 0;
        while (n < 20) step_edge();
        chk("pre_pulse_20", {20'd0, a_def}, 32'd20);
        rst = 1'b1;                 // edge+0.5
        #0.3 check_all_zero("async_clr");
        #2.7 rst = 1'b0;            // edge+3.5, next rising edge at edge+4
        n = 0;
        for (int k = 1; k <= 3; k++) begin
            step_edge();
            chk("post_pulse", {20'd0, a_def}, k);
        end
        for (int k = 0; k < 6; k++) step_edge();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case the sequence above stalls.
    initial begin
        #100000;
        $display("FAIL timeout n=%0d got no finish expected finish", n);
        $fatal(1, "timeout");
    end

endmodule
